// File: rtl/mult_hazard_sequencer.sv
// Hazard controller for the 5-stage core: load-use stalls plus sequencing of the
// iterative multiplier in EX (start, iterate, done/abort) with a stall-cycle counter.
module mult_hazard_sequencer #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              id_valid,
  input  logic              id_is_mult,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              mult_start,
  output logic              mult_en,
  output logic              mult_abort,
  output logic              mult_done,
  output logic              busy,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULT_CYCLES - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q;
  logic              load_use;
  logic              stall_raw, bubble_raw, start_raw, en_raw, abort_raw, done_raw, busy_raw;

  assign load_use = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_raw  = 1'b0;
    bubble_raw = 1'b0;
    start_raw  = 1'b0;
    en_raw     = 1'b0;
    abort_raw  = 1'b0;
    done_raw   = 1'b0;
    busy_raw   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StIdle;
        end else if (load_use) begin
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
        end else if (id_valid && id_is_mult) begin
          start_raw  = 1'b1;
          stall_raw  = 1'b1;
          bubble_raw = 1'b1;
          cnt_d      = CntLoad;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        busy_raw   = 1'b1;
        bubble_raw = 1'b1;
        if (flush) begin
          abort_raw = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          stall_raw = 1'b1;
          en_raw    = 1'b1;
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StDone: begin
        busy_raw  = 1'b1;
        abort_raw = flush;
        done_raw  = !flush;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are combinational from inputs, so force them low while reset is held.
  assign stall_if_id    = stall_raw  & arst_n;
  assign bubble_id_ex   = bubble_raw & arst_n;
  assign mult_start     = start_raw  & arst_n;
  assign mult_en        = en_raw     & arst_n;
  assign mult_abort     = abort_raw  & arst_n;
  assign mult_done      = done_raw   & arst_n;
  assign busy           = busy_raw   & arst_n;
  assign perf_stall_cnt = perf_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_if_id && (perf_q != '1)) begin
        perf_q <= perf_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_hazard_sequencer.sv
// Scoreboard bench: a transaction-level model predicts each cycle's outputs into a
// queue; a negedge monitor compares them against the DUT.
module tb_mult_hazard_sequencer;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        id_valid, id_is_mult, ex_mem_read, flush;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        stall_if_id, bubble_id_ex, mult_start, mult_en, mult_abort, mult_done, busy;
  logic [15:0] perf_stall_cnt;

  mult_hazard_sequencer #(.MULT_CYCLES(M), .CNT_W(3), .PERF_W(16)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .id_valid       (id_valid),
    .id_is_mult     (id_is_mult),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .flush          (flush),
    .stall_if_id    (stall_if_id),
    .bubble_id_ex   (bubble_id_ex),
    .mult_start     (mult_start),
    .mult_en        (mult_en),
    .mult_abort     (mult_abort),
    .mult_done      (mult_done),
    .busy           (busy),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  o;     // {stall, bubble, start, en, abort, done, busy}
    logic [15:0] perf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: a multiply in flight is tracked by its age in cycles since issue.
  bit   in_flight = 0;
  int   age       = 0;
  int   perf_m    = 0;

  logic [6:0] act;
  assign act = {stall_if_id, bubble_id_ex, mult_start, mult_en, mult_abort, mult_done, busy};

  task automatic model_reset();
    in_flight = 0;
    age       = 0;
    perf_m    = 0;
  endtask

  task automatic step(input bit v, input bit m, input logic [4:0] r1, input logic [4:0] r2,
                      input bit mr, input logic [4:0] rd, input bit fl);
    bit st, bb, sa, en, ab, dn, bz, lu;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    id_valid = v; id_is_mult = m; id_rs1 = r1; id_rs2 = r2;
    ex_mem_read = mr; ex_rd = rd; flush = fl;
    {st, bb, sa, en, ab, dn, bz} = '0;
    lu = v && mr && (rd != 0) && (rd == r1 || rd == r2);
    if (!in_flight) begin
      if (fl) begin
      end else if (lu) begin
        st = 1; bb = 1;
      end else if (v && m) begin
        sa = 1; st = 1; bb = 1;
        in_flight = 1; age = 1;
      end
    end else if (age < M) begin
      bz = 1; bb = 1;
      if (fl) begin
        ab = 1; in_flight = 0;
      end else begin
        st = 1; en = 1; age++;
      end
    end else begin
      bz = 1;
      if (fl) ab = 1;
      else    dn = 1;
      in_flight = 0;
    end
    e.o    = {st, bb, sa, en, ab, dn, bz};
    e.perf = 16'(perf_m);
    e.cyc  = cyc;
    q.push_back(e);
    if (st && perf_m < 65535) perf_m++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mul(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 5'd1, 5'd2, 0, 0, 0);
  endtask

  // Asserts reset asynchronously mid-cycle with a MUL presented, checks quiescent outputs.
  task automatic do_reset();
    @(negedge clk);
    #1;
    id_valid = 1; id_is_mult = 1; id_rs1 = 0; id_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; flush = 0;
    arst_n = 0;
    #1;
    checks++;
    if (act !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 0000000", act);
    end
    checks++;
    if (perf_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_perf: got %h, want 0000", perf_stall_cnt);
    end
    q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    id_valid = 0; id_is_mult = 0;
    arst_n = 1;
  endtask

  always @(negedge clk) begin
    if (arst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act !== e.o || perf_stall_cnt !== e.perf) begin
        errors++;
        $display("FAIL cycle_%0d outputs: got %b perf %h, want %b perf %h",
                 e.cyc, act, perf_stall_cnt, e.o, e.perf);
      end
    end
  end

  initial begin
    arst_n = 0;
    id_valid = 0; id_is_mult = 0; id_rs1 = 0; id_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; flush = 0;
    do_reset();

    // Single MUL: start at 0, en 1..3, done at 4, perf ends at 4.
    mul(1); mul(4); idle(2);

    // Load-use on rs2 blocks the MUL start for one cycle.
    step(1, 1, 5'd1, 5'd5, 1, 5'd5, 0);
    step(1, 1, 5'd1, 5'd5, 0, 5'd5, 0);
    idle(5);

    // Load into x0 never stalls.
    step(1, 0, 5'd0, 5'd3, 1, 5'd0, 0);
    step(1, 1, 5'd0, 5'd0, 1, 5'd0, 0);
    idle(5);

    // Flush while busy at cycle 2, then flush in DONE and flush in IDLE.
    mul(2); step(1, 1, 1, 2, 0, 0, 1); idle(3);
    mul(4); step(1, 1, 1, 2, 0, 0, 1); idle(2);
    step(1, 1, 1, 2, 0, 0, 1); idle(2);

    // Back-to-back MULs with ID held at MUL for 10 cycles.
    mul(10); idle(2);

    // Reset in the middle of a multiply.
    mul(2); do_reset(); mul(1); idle(5);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0);
    end
    idle(6);

    // Saturation: 2^16+3 load-use stall cycles from reset.
    do_reset();
    for (int i = 0; i < 65539; i++) step(1, 0, 5'd7, 5'd0, 1, 5'd7, 0);
    idle(1);
    @(negedge clk);
    #1;
    checks++;
    if (perf_stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL perf_saturate: got %h, want ffff", perf_stall_cnt);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
